// File: rtl/mcp4811_dac_ctrl.sv
// SPI write master for MCP4801/4811/4821 DACs: one code per handshake, 16-bit mode-0 frame,
// then a CS_n hold, a one-cycle gap and an LDAC_n strobe before the next code is accepted.
module mcp4811_dac_ctrl #(
  parameter int DAC_DATA_W = 10,
  parameter int SCK_DIV    = 2,
  parameter int LDAC_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DAC_DATA_W-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  done,
  output logic                  dac_cs_n,
  output logic                  dac_sck,
  output logic                  dac_sdi,
  output logic                  dac_ldac_n
);

  localparam int HALF_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int LDAC_CW = $clog2(LDAC_W + 1);

  generate
    if (DAC_DATA_W != 8 && DAC_DATA_W != 10 && DAC_DATA_W != 12) begin : g_bad_width
      $error("mcp4811_dac_ctrl: DAC_DATA_W must be 8, 10 or 12");
    end
    if (SCK_DIV < 1) begin : g_bad_div
      $error("mcp4811_dac_ctrl: SCK_DIV must be >= 1");
    end
    if (LDAC_W < 1) begin : g_bad_ldac
      $error("mcp4811_dac_ctrl: LDAC_W must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, CS_HOLD, LDAC} state_t;

  state_t              state;
  logic [HALF_W-1:0]   half_cnt;
  logic [3:0]          bit_cnt;
  logic [LDAC_CW-1:0]  ldac_cnt;
  logic [15:0]         shreg;
  logic [11:0]         code_aligned;
  logic [15:0]         frame;
  logic                half_last;

  // Narrower codes are left-aligned in the 12-bit data field; the low bits are don't-care pad.
  assign code_aligned = 12'(din) << (12 - DAC_DATA_W);
  assign frame        = {4'b0011, code_aligned};
  assign half_last    = (half_cnt == HALF_W'(SCK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      ldac_cnt   <= '0;
      shreg      <= '0;
      din_ready  <= 1'b1;
      done       <= 1'b0;
      dac_cs_n   <= 1'b1;
      dac_sck    <= 1'b0;
      dac_sdi    <= 1'b0;
      dac_ldac_n <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (din_valid && din_ready) begin
            state     <= SHIFT;
            din_ready <= 1'b0;
            dac_cs_n  <= 1'b0;
            dac_sdi   <= frame[15];
            shreg     <= {frame[14:0], 1'b0};
            half_cnt  <= '0;
            bit_cnt   <= '0;
          end
        end
        SHIFT: begin
          if (half_last) begin
            half_cnt <= '0;
            if (!dac_sck) begin
              dac_sck <= 1'b1;
            end else begin
              // Data moves only on the falling edge; after bit 15 the empty register shifts out 0.
              dac_sck <= 1'b0;
              dac_sdi <= shreg[15];
              shreg   <= {shreg[14:0], 1'b0};
              if (bit_cnt == 4'd15) begin
                state <= CS_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        CS_HOLD: begin
          if (half_last) begin
            half_cnt <= '0;
            dac_cs_n <= 1'b1;
            ldac_cnt <= '0;
            state    <= LDAC;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        LDAC: begin
          // First cycle here is the CS_n-high gap; LDAC_n then stays low for LDAC_W cycles.
          if (ldac_cnt == LDAC_CW'(LDAC_W)) begin
            dac_ldac_n <= 1'b1;
            done       <= 1'b1;
            din_ready  <= 1'b1;
            state      <= IDLE;
          end else begin
            dac_ldac_n <= 1'b0;
            ldac_cnt   <= ldac_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
